// File: rtl/mac_stat_agg_pkg.sv
// mac_stat_pkg: shared kind encodings, address stride and report FSM states for mac_stat_agg
package mac_stat_pkg;
  localparam int K_RX = 0;
  localparam int K_TX = 1;
  localparam int K_ER = 2;
  localparam int NUM_KINDS = 3;
  localparam int ADDR_STRIDE = 4;
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
endpackage

// File: rtl/mac_stat_agg_if.sv
// mac_stat_agg_if: statistic write port; master drives addr/din/req (req held until ack), slave returns one-cycle ack
interface mac_stat_agg_if;
  logic [6:0] addr;
  logic [15:0] din;
  logic req;
  logic ack;
  modport master(output addr, din, req, input ack);
  modport slave(input addr, din, req, output ack);
endinterface

// File: rtl/mac_stat_cnt.sv
// mac_stat_cnt: saturating event counter with snapshot-and-clear; ports clk, rstn_sys, inc, snap -> live, shadow
module mac_stat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn_sys,
  input  logic             inc,
  input  logic             snap,
  output logic [CNT_W-1:0] live,
  output logic [CNT_W-1:0] shadow
);
  always_ff @(posedge clk or negedge rstn_sys)
    if (!rstn_sys) begin
      live <= '0;
      shadow <= '0;
    end else if (snap) begin
      shadow <= live;
      live <= CNT_W'(inc);
    end else if (inc && !(&live))
      live <= live + 1'b1;
endmodule

// File: rtl/mac_stat_agg.sv
// mac_stat_agg: per-port rx/tx/er frame counters reported every PERIOD cycles; ports clk, rstn_sys, stat_en, rx/tx/er_pkt, port (write bus), stat_overrun
module mac_stat_agg
  import mac_stat_pkg::*;
#(
  parameter int         NUM_PORTS = 4,
  parameter int         CNT_W     = 16,
  parameter int         PERIOD    = 200000,
  parameter logic [6:0] BASE_ADDR = 7'h10
) (
  input  logic                 clk,
  input  logic                 rstn_sys,
  input  logic                 stat_en,
  input  logic [NUM_PORTS-1:0] rx_pkt,
  input  logic [NUM_PORTS-1:0] tx_pkt,
  input  logic [NUM_PORTS-1:0] er_pkt,
  mac_stat_agg_if.master       port,
  output logic                 stat_overrun
);
  localparam int NC = NUM_KINDS * NUM_PORTS;
  localparam int IW = $clog2(NC);
  localparam int PW = $clog2(PERIOD);
  state_t state;
  logic [IW-1:0] idx;
  logic [PW-1:0] pcnt;
  logic tick, snap;
  logic [CNT_W-1:0] live [NC];
  logic [CNT_W-1:0] shd [NC];
  logic [6:0] addr_tab [NC];
  assign tick = pcnt == PW'(PERIOD - 1);
  assign snap = tick && state == IDLE;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar k = 0; k < NUM_KINDS; k++) begin : g_kind
      assign addr_tab[NUM_KINDS*p+k] = BASE_ADDR + 7'(ADDR_STRIDE * p + k);
      mac_stat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk),
        .rstn_sys(rstn_sys),
        .inc(stat_en && (k == K_RX ? rx_pkt[p] : k == K_TX ? tx_pkt[p] : er_pkt[p])),
        .snap(snap),
        .live(live[NUM_KINDS*p+k]),
        .shadow(shd[NUM_KINDS*p+k])
      );
    end
  end
  always_ff @(posedge clk or negedge rstn_sys)
    if (!rstn_sys) begin
      state <= IDLE;
      idx <= '0;
      pcnt <= '0;
      port.req <= 1'b0;
      port.addr <= '0;
      port.din <= '0;
      stat_overrun <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      stat_overrun <= tick && state != IDLE;
      case (state)
        IDLE: if (tick) begin
          state <= REQ;
          idx <= '0;
          port.req <= 1'b1;
          port.addr <= addr_tab[0];
          // shadow[0] is loaded on this same edge, so take the value it is loaded from
          port.din <= 16'(live[0]);
        end
        REQ: if (port.ack) begin
          state <= idx == IW'(NC - 1) ? IDLE : GAP;
          idx <= idx == IW'(NC - 1) ? idx : idx + 1'b1;
          port.req <= 1'b0;
          port.addr <= '0;
          port.din <= '0;
        end
        GAP: begin
          state <= REQ;
          port.req <= 1'b1;
          port.addr <= addr_tab[idx];
          port.din <= 16'(shd[idx]);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mac_stat_agg.sv
// tb_mac_stat_agg: randomized and directed checks of mac_stat_agg against a pulse-counting reference model
module tb_mac_stat_agg;
  localparam int NP = 2;
  localparam int CW = 4;
  localparam int P = 64;
  localparam logic [6:0] BA = 7'h10;
  localparam int NC = 3 * NP;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rstn_sys = 1'b0;
  logic stat_en = 1'b0;
  logic [NP-1:0] rx_pkt = '0, tx_pkt = '0, er_pkt = '0;
  logic stat_overrun;
  mac_stat_agg_if bus();

  mac_stat_agg #(.NUM_PORTS(NP), .CNT_W(CW), .PERIOD(P), .BASE_ADDR(BA)) dut (
    .clk(clk),
    .rstn_sys(rstn_sys),
    .stat_en(stat_en),
    .rx_pkt(rx_pkt),
    .tx_pkt(tx_pkt),
    .er_pkt(er_pkt),
    .port(bus.master),
    .stat_overrun(stat_overrun)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [22:0] got_q[$], exp_q[$];
  int sc, first_req, unstable, idle_bad, ovr_cnt, exp_ovr, req_age, ack_dly;
  bit ack_en, prev_req;
  logic [22:0] held;

  // reference model: raw pulse counts per period, saturated only when reported
  int live_m [NP][3];
  int cyc, pend, pb, v;
  bit tk;
  always @(posedge clk) begin
    if (!rstn_sys) begin
      cyc = 0;
      pend = 0;
      for (int p = 0; p < NP; p++) for (int k = 0; k < 3; k++) live_m[p][k] = 0;
    end else begin
      tk = (cyc % P) == P - 1;
      pb = pend;
      cyc++;
      if (bus.ack) pend--;
      if (tk && pb == 0) begin
        for (int i = 0; i < NC; i++) begin
          v = live_m[i/3][i%3] > MAXV ? MAXV : live_m[i/3][i%3];
          exp_q.push_back({7'(BA + 4 * (i / 3) + i % 3), 16'(v)});
          live_m[i/3][i%3] = 0;
        end
        pend = NC;
      end else if (tk) exp_ovr++;
      for (int p = 0; p < NP; p++) begin
        if (stat_en && rx_pkt[p]) live_m[p][0]++;
        if (stat_en && tx_pkt[p]) live_m[p][1]++;
        if (stat_en && er_pkt[p]) live_m[p][2]++;
      end
    end
  end

  // one cycle: observe outputs at negedge, decide ack, then drive pulses for the next edge
  task automatic step(input logic [NP-1:0] rx = '0, tx = '0, er = '0);
    @(negedge clk);
    sc++;
    if (bus.req) begin
      if (!prev_req) begin
        held = {bus.addr, bus.din};
        if (first_req < 0) first_req = sc;
      end else if ({bus.addr, bus.din} !== held) unstable++;
    end else if (bus.addr !== 7'd0 || bus.din !== 16'd0) idle_bad++;
    if (stat_overrun) ovr_cnt++;
    bus.ack = bus.req && ack_en && req_age >= ack_dly;
    if (bus.ack) got_q.push_back({bus.addr, bus.din});
    req_age = (bus.req && !bus.ack) ? req_age + 1 : 0;
    prev_req = bus.req;
    rx_pkt = rx;
    tx_pkt = tx;
    er_pkt = er;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rstn_sys = 1'b0;
    bus.ack = 1'b0;
    rx_pkt = '0;
    tx_pkt = '0;
    er_pkt = '0;
    ack_en = 1'b1;
    ack_dly = 0;
    stat_en = 1'b1;
    repeat (3) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    sc = 0;
    first_req = -1;
    unstable = 0;
    idle_bad = 0;
    ovr_cnt = 0;
    exp_ovr = 0;
    req_age = 0;
    prev_req = 1'b0;
    rstn_sys = 1'b1;
  endtask

  task automatic wait_writes(input int n, input int budget);
    while (got_q.size() < n && budget > 0) begin
      step();
      budget--;
    end
  endtask

  function automatic logic [NP-1:0] sparse();
    return NP'($urandom & $urandom & $urandom & $urandom);
  endfunction

  task automatic test_reset;
    rstn_sys = 1'b0;
    bus.ack = 1'b1;
    rx_pkt = '1;
    repeat (2) @(negedge clk);
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", bus.req); end
    total++; if (bus.addr !== 7'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", bus.addr); end
    total++; if (bus.din !== 16'd0) begin bad++; $display("FAIL reset_din got=%0h exp=0", bus.din); end
    total++; if (stat_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", stat_overrun); end
  endtask

  task automatic test_basic;
    int ea[6] = '{'h10, 'h11, 'h12, 'h14, 'h15, 'h16};
    int ev[6] = '{0, 0, 2, 5, 0, 0};
    do_reset();
    ack_dly = 2;
    for (int i = 0; i < 10; i++) step(i < 5 ? 2'b10 : 2'b00, 2'b00, i < 2 ? 2'b01 : 2'b00);
    wait_writes(6, 200);
    total++; if (got_q.size() != 6) begin bad++; $display("FAIL basic_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got_q[i] !== {7'(ea[i]), 16'(ev[i])})
        begin bad++; $display("FAIL basic_write%0d got=%0h exp=%0h", i, got_q[i], {7'(ea[i]), 16'(ev[i])}); end
    end
    total++; if (first_req != P) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", first_req, P); end
    total++; if (unstable != 0) begin bad++; $display("FAIL basic_stable got=%0d exp=0", unstable); end
    total++; if (idle_bad != 0) begin bad++; $display("FAIL basic_idle_zero got=%0d exp=0", idle_bad); end
  endtask

  task automatic test_tick_edge;
    do_reset();
    repeat (P - 2) step();
    step(2'b01, 2'b00, 2'b00);
    wait_writes(12, 200);
    total++; if (got_q[0] !== {7'h10, 16'd0}) begin bad++; $display("FAIL tick_first got=%0h exp=%0h", got_q[0], {7'h10, 16'd0}); end
    total++; if (got_q[6] !== {7'h10, 16'd1}) begin bad++; $display("FAIL tick_next got=%0h exp=%0h", got_q[6], {7'h10, 16'd1}); end
  endtask

  task automatic test_saturate;
    do_reset();
    repeat (20) begin
      step(2'b00, 2'b01, 2'b00);
      step();
    end
    wait_writes(6, 200);
    total++; if (got_q[1] !== {7'h11, 16'd15}) begin bad++; $display("FAIL sat_tx0 got=%0h exp=%0h", got_q[1], {7'h11, 16'd15}); end
  endtask

  task automatic test_overrun;
    do_reset();
    ack_en = 1'b0;
    while (sc < 140) step(sparse(), sparse(), sparse());
    ack_en = 1'b1;
    ack_dly = 1;
    while (sc < 200) step(sparse(), sparse(), sparse());
    wait_writes(12, 300);
    total++; if (ovr_cnt != 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt); end
    total++; if (got_q.size() < 12 || exp_q.size() < 12) begin bad++; $display("FAIL ovr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovr_write%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    ack_dly = 3;
    step(2'b11, 2'b00, 2'b00);
    while (first_req < 0 && sc < 2 * P) step();
    rstn_sys = 1'b0;
    #1;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%0b exp=0", bus.req); end
    total++; if (bus.addr !== 7'd0) begin bad++; $display("FAIL rmid_addr got=%0h exp=0", bus.addr); end
    do_reset();
    repeat (P - 1) step();
    total++; if (first_req != -1) begin bad++; $display("FAIL rmid_quiet got=%0d exp=-1", first_req); end
    step();
    total++; if (first_req != P) begin bad++; $display("FAIL rmid_first got=%0d exp=%0d", first_req, P); end
  endtask

  task automatic test_stat_en;
    do_reset();
    stat_en = 1'b0;
    ack_dly = 1;
    repeat (10) begin
      step('1, '1, '1);
      step();
    end
    wait_writes(6, 200);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got_q[i][15:0] !== 16'd0) begin bad++; $display("FAIL en_off%0d got=%0h exp=0", i, got_q[i][15:0]); end
    end
  endtask

  task automatic test_random;
    int budget = 300;
    do_reset();
    while (sc < 3 * P + 10) begin
      stat_en = $urandom_range(0, 7) != 0;
      ack_dly = $urandom_range(0, 3);
      step(NP'($urandom & $urandom), NP'($urandom & $urandom), sparse());
    end
    stat_en = 1'b1;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      step();
      budget--;
    end
    total++; if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_write%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
    end
    total++; if (ovr_cnt != exp_ovr) begin bad++; $display("FAIL rnd_overrun got=%0d exp=%0d", ovr_cnt, exp_ovr); end
    total++; if (unstable != 0) begin bad++; $display("FAIL rnd_stable got=%0d exp=0", unstable); end
    total++; if (idle_bad != 0) begin bad++; $display("FAIL rnd_idle_zero got=%0d exp=0", idle_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tick_edge();
    test_saturate();
    test_overrun();
    test_reset_mid();
    test_stat_en();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_stat_agg.md
MAC_STAT_AGG -- requirements
Module: mac_stat_agg

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rstn_sys; no other clock or reset SHALL exist.
REQ-002 Parameter NUM_PORTS, default 4: number of MAC ports aggregated, range 1..8.
REQ-003 Parameter CNT_W, default 16: counter width, range 4..16.
REQ-004 Parameter PERIOD, default 200000: report interval in clk cycles, minimum 3*NUM_PORTS*4.
REQ-005 Parameter BASE_ADDR, default 7'h10: port_addr of port 0, rx kind.
REQ-006 clk  in  1  system clock.
REQ-007 rstn_sys  in  1  asynchronous active-low reset.
REQ-008 stat_en  in  1  high = counters accumulate; low = counters hold.
REQ-009 rx_pkt  in  NUM_PORTS  one-cycle pulse per received frame, bit p = port p.
REQ-010 tx_pkt  in  NUM_PORTS  one-cycle pulse per transmitted frame.
REQ-011 er_pkt  in  NUM_PORTS  one-cycle pulse per errored frame.
REQ-012 port_addr  out  7  statistic register address.
REQ-013 port_din  out  16  statistic value, zero-extended from CNT_W.
REQ-014 port_req  out  1  write request, held until acknowledged.
REQ-015 port_ack  in  1  one-cycle acknowledge.
REQ-016 stat_overrun  out  1  one-cycle pulse when a period tick is dropped.

Function
REQ-017 3*NUM_PORTS live counters SHALL exist, kind k in {rx=0, tx=1, er=2}; each SHALL increment by 1 on its pulse when stat_en=1 and SHALL saturate at 2^CNT_W-1.
REQ-018 A period counter SHALL count 0..PERIOD-1 and wrap; the tick SHALL be the cycle it equals PERIOD-1.
REQ-019 FSM states SHALL be IDLE, REQ, GAP.
REQ-020 On a tick in IDLE: at the next edge every live counter SHALL be copied to its shadow register, each live counter SHALL load 1 if its pulse is high that cycle (with stat_en=1), else 0, index SHALL reset to 0, and the FSM SHALL enter REQ; no pulse SHALL be lost or double counted.
REQ-021 In REQ, port_req SHALL be 1, port_addr SHALL equal BASE_ADDR + 4*p + k and port_din SHALL equal shadow[p][k], where index = 3*p + k.
REQ-022 port_req SHALL rise in the first cycle after the snapshot edge (latency 1 cycle from tick edge).
REQ-023 On port_ack=1 in REQ: if index = 3*NUM_PORTS-1 the FSM SHALL go to IDLE, else index SHALL increment and the FSM SHALL go to GAP.
REQ-024 GAP SHALL last exactly one cycle with port_req=0, then return to REQ.
REQ-025 port_ack outside REQ SHALL be ignored.
REQ-026 A tick while the FSM is in REQ or GAP SHALL NOT snapshot or clear; live counters SHALL keep accumulating, and stat_overrun SHALL pulse for one cycle.
REQ-027 port_addr and port_din SHALL be stable for as long as port_req=1.
REQ-028 In IDLE and GAP, port_addr and port_din SHALL be 0.

Reset
REQ-029 Reset SHALL clear all live counters, shadow registers, period counter and index to 0, force IDLE, and drive port_req=0, port_addr=0, port_din=0 and stat_overrun=0.
REQ-030 Reset asserted mid-report SHALL abandon the report; after release the first report SHALL occur on the first tick, PERIOD cycles later.

Structure
REQ-031 Package mac_stat_pkg SHALL hold the kind encodings (K_RX=0, K_TX=1, K_ER=2), NUM_KINDS=3, ADDR_STRIDE=4 and the FSM state encoding.
REQ-032 Sub-module mac_stat_cnt (one saturating counter with snapshot-and-clear, CNT_W parameter) SHALL be instantiated 3*NUM_PORTS times.

Verification
REQ-033 NUM_PORTS=2, PERIOD=64: 5 rx pulses on port 1 and 2 er pulses on port 0, ack after 2 cycles -> six writes in order: addr 10,11,12,14,15,16 with values 0,0,2,5,0,0.
REQ-034 rx_pkt[0] pulse exactly on the tick cycle -> reported value excludes it; the next period reports 1.
REQ-035 CNT_W=4: 20 tx pulses on port 0 in one period -> port_din=15 for addr 11.
REQ-036 Ack withheld past the next tick -> stat_overrun pulses once; the following report contains the counts from both periods.
REQ-037 rstn_sys low while port_req=1 -> port_req=0 immediately; no write for PERIOD cycles after release.
REQ-038 stat_en=0 with 10 pulses on all inputs -> all reported values 0.
